// File: rtl/t_inst_first_seq_if.sv
// Link between the stimulus sequencer and the block it drives: the drive buses
// and the block's echoes, including the one-cycle-registered copy of the 5-bit bus.
interface t_inst_first_seq_if;
    logic [4:0]   o_w5;
    logic [39:0]  o_w40;
    logic [103:0] o_w104;
    logic [4:0]   i_w5;
    logic [4:0]   i_w5_d1r;
    logic [39:0]  i_w40;
    logic [103:0] i_w104;

    modport master (
        output o_w5, o_w40, o_w104,
        input  i_w5, i_w5_d1r, i_w40, i_w104
    );

    modport slave (
        input  o_w5, o_w40, o_w104,
        output i_w5, i_w5_d1r, i_w40, i_w104
    );
endinterface

// File: rtl/t_inst_first_seq.sv
// LFSR-driven stimulus sequencer that checks combinational and registered echoes.
// Define T_INST_FIRST_SEQ_ERRCAP_EN to latch the index and bus mask of the first error.
module t_inst_first_seq #(
    parameter int          NUM_VEC = 16,
    parameter logic [31:0] SEED    = 32'hACE1_2345
) (
    input  logic               clk,
    input  logic               reset_l,
    input  logic               start,
    t_inst_first_seq_if.master lnk,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [7:0]         err_count,
    output logic [7:0]         first_err_idx,
    output logic [2:0]         first_err_mask
);

    localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [7:0]  LAST_IDX  = 8'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] lfsr;
    logic [4:0]  prev_w5;
    logic        prev_valid;
    logic [7:0]  vec_idx;

    logic        load_seed;
    logic        step;
    logic        finish;
    logic        last_vec;
    logic [2:0]  chk_mask;
    logic        err_hit;
    logic [7:0]  err_final;
    logic [31:0] lfsr_nxt;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_MASK : 32'h0);
    endfunction

    function automatic logic [39:0] w40_of(input logic [31:0] l);
        return {l[7:0], l};
    endfunction

    function automatic logic [103:0] w104_of(input logic [31:0] l);
        return {l[7:0], l, l, l};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic inc);
        if (!inc || cnt == 8'hFF)
            return cnt;
        return cnt + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (vec_idx == LAST_IDX) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_DONE;
            ST_DONE:  if (start) state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Check decode: RUN compares every bus, DRAIN only the last delayed copy.
    always_comb begin
        load_seed = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        chk_mask  = 3'b000;
        case (state)
            ST_IDLE, ST_DONE: load_seed = start;
            ST_RUN: begin
                step     = 1'b1;
                chk_mask = {(lnk.i_w104 !== lnk.o_w104),
                            (lnk.i_w40 !== lnk.o_w40),
                            (lnk.i_w5 !== lnk.o_w5) ||
                            (prev_valid && (lnk.i_w5_d1r !== prev_w5))};
            end
            ST_DRAIN: begin
                finish   = 1'b1;
                chk_mask = {2'b00, prev_valid && (lnk.i_w5_d1r !== prev_w5)};
            end
            default: ;
        endcase
    end

    assign err_hit   = |chk_mask;
    assign err_final = sat_inc(err_count, err_hit);
    assign last_vec  = (vec_idx == LAST_IDX);
    assign lfsr_nxt  = lfsr_step(lfsr);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            lfsr       <= SEED_EFF;
            lnk.o_w5   <= '0;
            lnk.o_w40  <= '0;
            lnk.o_w104 <= '0;
            prev_w5    <= '0;
            prev_valid <= 1'b0;
            vec_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
        end else if (load_seed) begin
            lfsr       <= SEED_EFF;
            lnk.o_w5   <= SEED_EFF[4:0];
            lnk.o_w40  <= w40_of(SEED_EFF);
            lnk.o_w104 <= w104_of(SEED_EFF);
            prev_valid <= 1'b0;
            vec_idx    <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
        end else if (step) begin
            err_count  <= err_final;
            prev_w5    <= lnk.o_w5;
            prev_valid <= 1'b1;
            vec_idx    <= vec_idx + 8'd1;
            // The last vector stays on the bus so DRAIN can see its registered echo.
            if (!last_vec) begin
                lfsr       <= lfsr_nxt;
                lnk.o_w5   <= lfsr_nxt[4:0];
                lnk.o_w40  <= w40_of(lfsr_nxt);
                lnk.o_w104 <= w104_of(lfsr_nxt);
            end
        end else if (finish) begin
            err_count <= err_final;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (err_final == 8'd0);
        end
    end

`ifdef T_INST_FIRST_SEQ_ERRCAP_EN
    logic err_seen;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            err_seen       <= 1'b0;
            first_err_idx  <= '0;
            first_err_mask <= '0;
        end else if (load_seed) begin
            err_seen       <= 1'b0;
            first_err_idx  <= '0;
            first_err_mask <= '0;
        end else if ((step || finish) && err_hit && !err_seen) begin
            // vec_idx already reads NUM_VEC while draining.
            err_seen       <= 1'b1;
            first_err_idx  <= vec_idx;
            first_err_mask <= chk_mask;
        end
    end
`else
    assign first_err_idx  = '0;
    assign first_err_mask = '0;
`endif

endmodule

// File: tb/tb_t_inst_first_seq.sv
// Directed bench for t_inst_first_seq: loopback, injected faults, saturation,
// mid-run reset and start-pulse handling, with hand-computed expectations.
module tb_t_inst_first_seq;

`ifdef T_INST_FIRST_SEQ_ERRCAP_EN
    localparam bit ERRCAP = 1'b1;
`else
    localparam bit ERRCAP = 1'b0;
`endif

    // Vector 5 of the default seed: L5 = 32'hBD49_0919.
    localparam logic [39:0]  V5_W40   = 40'h19_BD49_0919;
    localparam logic [39:0]  V0_W40   = 40'h45_ACE1_2345;
    localparam logic [103:0] V0_W104  = {8'h45, 32'hACE1_2345, 32'hACE1_2345, 32'hACE1_2345};
    localparam logic [39:0]  BIT17    = 40'h00_0002_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_l;
    logic start16;
    logic start255;
    int   mode;
    int   n_checks = 0;
    int   n_errors = 0;

    logic       busy16, done16, pass16;
    logic [7:0] err16, idx16;
    logic [2:0] mask16;
    logic       busy255, done255, pass255;
    logic [7:0] err255, idx255;
    logic [2:0] mask255;

    t_inst_first_seq_if lnk16 ();
    t_inst_first_seq_if lnk255 ();

    t_inst_first_seq #(.NUM_VEC(16)) dut16 (
        .clk            (clk),
        .reset_l        (reset_l),
        .start          (start16),
        .lnk            (lnk16),
        .busy           (busy16),
        .done           (done16),
        .pass           (pass16),
        .err_count      (err16),
        .first_err_idx  (idx16),
        .first_err_mask (mask16)
    );

    t_inst_first_seq #(.NUM_VEC(255)) dut255 (
        .clk            (clk),
        .reset_l        (reset_l),
        .start          (start255),
        .lnk            (lnk255),
        .busy           (busy255),
        .done           (done255),
        .pass           (pass255),
        .err_count      (err255),
        .first_err_idx  (idx255),
        .first_err_mask (mask255)
    );

    // Model of the downstream block: combinational echo plus registered 5-bit copy.
    logic [4:0] d1_16, d2_16, d1_255;
    always @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            d1_16  <= '0;
            d2_16  <= '0;
            d1_255 <= '0;
        end else begin
            d1_16  <= lnk16.o_w5;
            d2_16  <= d1_16;
            d1_255 <= lnk255.o_w5;
        end
    end

    assign lnk16.i_w5     = lnk16.o_w5;
    assign lnk16.i_w40    = lnk16.o_w40 ^ ((mode == 1 && lnk16.o_w40 == V5_W40) ? BIT17 : 40'h0);
    assign lnk16.i_w104   = lnk16.o_w104;
    assign lnk16.i_w5_d1r = (mode == 2) ? d2_16 : d1_16;

    assign lnk255.i_w5     = lnk255.o_w5;
    assign lnk255.i_w40    = lnk255.o_w40;
    assign lnk255.i_w104   = 'x;
    assign lnk255.i_w5_d1r = ~d1_255;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done16(input int limit, inout int clks);
        while (!done16 && clks < limit) begin
            @(posedge clk);
            @(negedge clk);
            clks++;
        end
    endtask

    task automatic run16(output int clks);
        start16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        clks = 1;
        wait_done16(40, clks);
    endtask

    task automatic pulse16();
        start16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
    endtask

    int clks;

    initial begin
        reset_l  = 1'b0;
        start16  = 1'b0;
        start255 = 1'b0;
        mode     = 0;
        repeat (2) @(negedge clk);

        chk("rst_busy",  busy16, 0);
        chk("rst_done",  done16, 0);
        chk("rst_pass",  pass16, 0);
        chk("rst_err",   err16, 0);
        chk("rst_w5",    lnk16.o_w5, 0);
        chk("rst_w40",   lnk16.o_w40, 0);
        chk("rst_w104",  lnk16.o_w104, 0);
        chk("rst_idx",   idx16, 0);
        chk("rst_mask",  mask16, 0);

        reset_l = 1'b1;
        @(negedge clk);

        // Clean loopback
        run16(clks);
        chk("t1_latency", clks, 18);
        chk("t1_done",    done16, 1);
        chk("t1_busy",    busy16, 0);
        chk("t1_err",     err16, 0);
        chk("t1_pass",    pass16, 1);

        // Single flipped bit on the 40-bit echo for vector 5
        mode = 1;
        run16(clks);
        chk("t2_latency", clks, 18);
        chk("t2_err",     err16, 1);
        chk("t2_pass",    pass16, 0);
        chk("t2_idx",     idx16, ERRCAP ? 8'd5 : 8'd0);
        chk("t2_mask",    mask16, ERRCAP ? 3'b010 : 3'b000);

        // Registered echo two cycles late
        mode = 2;
        run16(clks);
        chk("t3_err",     err16, 16);
        chk("t3_pass",    pass16, 0);
        chk("t3_idx",     idx16, ERRCAP ? 8'd1 : 8'd0);
        chk("t3_mask",    mask16, ERRCAP ? 3'b001 : 3'b000);
        mode = 0;

        // 255 vectors, every cycle bad plus a bad drain: 256 errors saturate at 255
        start255 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start255 = 1'b0;
        clks = 1;
        while (!done255 && clks < 300) begin
            @(posedge clk);
            @(negedge clk);
            clks++;
        end
        chk("t4_latency", clks, 257);
        chk("t4_err",     err255, 8'hFF);
        chk("t4_pass",    pass255, 0);
        chk("t4_idx",     idx255, 8'd0);
        chk("t4_mask",    mask255, ERRCAP ? 3'b100 : 3'b000);

        // Reset while vector 7 is on the bus
        pulse16();
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("t5_v7_w5", lnk16.o_w5, 5'h04);
        reset_l = 1'b0;
        #1;
        chk("t5_busy",  busy16, 0);
        chk("t5_done",  done16, 0);
        chk("t5_err",   err16, 0);
        chk("t5_w5",    lnk16.o_w5, 0);
        chk("t5_w40",   lnk16.o_w40, 0);
        chk("t5_w104",  lnk16.o_w104, 0);
        @(negedge clk);
        reset_l = 1'b1;
        @(negedge clk);
        run16(clks);
        chk("t5_latency", clks, 18);
        chk("t5_pass",    pass16, 1);
        chk("t5_err2",    err16, 0);

        // start during RUN is ignored, start during DONE restarts from the seed
        pulse16();
        chk("t6_v0_w5",   lnk16.o_w5, 5'h05);
        chk("t6_v0_w40",  lnk16.o_w40, V0_W40);
        chk("t6_v0_w104", lnk16.o_w104, V0_W104);
        repeat (3) @(posedge clk);
        @(negedge clk);
        pulse16();
        chk("t6_run_busy", busy16, 1);
        chk("t6_run_w5",   lnk16.o_w5, 5'h15);
        clks = 0;
        wait_done16(30, clks);
        chk("t6_done1", done16, 1);
        chk("t6_pass1", pass16, 1);
        pulse16();
        chk("t6_rst_busy", busy16, 1);
        chk("t6_rst_done", done16, 0);
        chk("t6_rst_w5",   lnk16.o_w5, 5'h05);
        chk("t6_rst_w104", lnk16.o_w104, V0_W104);
        clks = 1;
        wait_done16(40, clks);
        chk("t6_latency", clks, 18);
        chk("t6_pass2",   pass16, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
